// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer for the data-side SRAM-like bus.
// Formats store data/strobes, issues one bus transaction per access, extends
// load data and stalls the pipeline until the access completes.
// Optional feature macro: MEM_ALIGN_CHECK_EN (adds adel/ades/badvaddr and
// suppresses misaligned accesses; otherwise low address bits are force-aligned).
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        memwrite,
  input  logic              memtoreg,
  input  logic [1:0]        load_size,
  input  logic              load_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state, state_n;
  logic              killed;     // accepted transaction was flushed; drain it silently
  logic              lsign_q;
  logic              is_store, access, misalign, start;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] al_addr;
  logic [3:0]        st_strb;
  logic [31:0]       st_data, sh, ext;
  logic              capture;

  // Decode the MEM instruction: size, alignment and formatted store fields
  always_comb begin
    is_store = |memwrite;
    access   = is_store | memtoreg;
    if (is_store)
      req_size = memwrite[3] ? 2'd2 : (memwrite[1] ? 2'd1 : 2'd0);
    else
      req_size = (load_size == 2'd0) ? 2'd0 : ((load_size == 2'd1) ? 2'd1 : 2'd2);
`ifdef MEM_ALIGN_CHECK_EN
    misalign = ((req_size == 2'd1) & addr[0]) | ((req_size == 2'd2) & (addr[1:0] != 2'b00));
    al_addr  = addr;
`else
    misalign = 1'b0;
    al_addr  = addr;
    if (req_size == 2'd1) al_addr[0]   = 1'b0;
    if (req_size == 2'd2) al_addr[1:0] = 2'b00;
`endif
    case (req_size)
      2'd0:    begin st_strb = 4'b0001 << al_addr[1:0];         st_data = {4{wdata[7:0]}};  end
      2'd1:    begin st_strb = 4'b0011 << {al_addr[1], 1'b0};   st_data = {2{wdata[15:0]}}; end
      default: begin st_strb = 4'b1111;                          st_data = wdata;            end
    endcase
    if (!is_store) st_strb = 4'b0000;
    start = (state == S_IDLE) & en & ~flush & access & ~misalign;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a flushed access that was already accepted drains to IDLE
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_REQ;
      S_REQ: begin
        if (data_addr_ok && data_data_ok) state_n = flush ? S_IDLE : S_DONE;
        else if (data_addr_ok)            state_n = S_WAIT;
        else if (flush)                   state_n = S_IDLE;
      end
      S_WAIT: if (data_data_ok) state_n = (flush | killed) ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pipeline-facing outputs
  always_comb begin
    stall = start | (state == S_REQ) | (state == S_WAIT);
    done  = (state == S_DONE);
  end

  // Remember a flush that hit after the slave accepted the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      killed <= 1'b0;
    else if (state_n != S_WAIT)   killed <= 1'b0;
    else if (flush)               killed <= 1'b1;
  end

  // Registered bus request; fields hold until the slave accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wstrb <= 4'b0000;
      data_wdata <= 32'h0;
      lsign_q    <= 1'b0;
    end else if (start) begin
      data_req   <= 1'b1;
      data_wr    <= is_store;
      data_size  <= req_size;
      data_addr  <= al_addr;
      data_wstrb <= st_strb;
      data_wdata <= st_data;
      lsign_q    <= load_sign;
    end else if (state == S_REQ && (data_addr_ok || flush)) begin
      data_req   <= 1'b0;
    end
  end

  // Load extraction: shift the addressed lane down, then extend
  always_comb begin
    sh = data_rdata >> {data_addr[1:0], 3'b000};
    case (data_size)
      2'd0:    ext = {{24{lsign_q & sh[7]}},  sh[7:0]};
      2'd1:    ext = {{16{lsign_q & sh[15]}}, sh[15:0]};
      default: ext = data_rdata;
    endcase
    capture = ~data_wr & data_data_ok & ~flush & ~killed &
              (((state == S_REQ) & data_addr_ok) | (state == S_WAIT));
  end

  // Load result register, only updated by a completing (unflushed) load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata <= 32'h0;
    else if (capture) rdata <= ext;
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Address-error reporting: one-cycle pulse plus faulting address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adel     <= 1'b0;
      ades     <= 1'b0;
      badvaddr <= '0;
    end else begin
      adel <= (state == S_IDLE) & en & ~flush & access & misalign & ~is_store;
      ades <= (state == S_IDLE) & en & ~flush & misalign & is_store;
      if ((state == S_IDLE) & en & ~flush & access & misalign) badvaddr <= addr;
    end
  end
`endif

endmodule
